// File: rtl/multicycle_ctrl_if.sv
// Unified memory port handshake between the
// multi-cycle control unit and the memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control FSM: fetch, decode,
// execute, memory, writeback, with bus timeout trap.
module multicycle_ctrl #(
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              br_eq,
  input  logic              br_lt,
  multicycle_ctrl_if.master mem,
  output logic              pc_sel,
  output logic              pc_wen,
  output logic              ir_wen,
  output logic [2:0]        imm_sel,
  output logic              a_sel,
  output logic              b_sel,
  output logic              br_un,
  output logic [3:0]        alu_op,
  output logic [1:0]        wb_sel,
  output logic              reg_wen,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t          st, st_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic            ill_q, bus_q;
  logic            set_ill, set_bus;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_ld, is_st, is_op, is_opi;
  logic       is_br, is_jal, is_jalr;
  logic       is_lui, is_aui;
  logic       legal, taken;
  logic       stall, tout;
  logic [2:0] imm_d;
  logic [3:0] alu_d;
  logic       a_d, b_d;
  logic       unused_bits;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign unused_bits =
    ^{instr[31], instr[29:15], instr[11:7]};

  assign is_ld   = opc == OP_LOAD;
  assign is_st   = opc == OP_STORE;
  assign is_op   = opc == OP_OP;
  assign is_opi  = opc == OP_OPIMM;
  assign is_br   = opc == OP_BR;
  assign is_jal  = opc == OP_JAL;
  assign is_jalr = opc == OP_JALR;
  assign is_lui  = opc == OP_LUI;
  assign is_aui  = opc == OP_AUIPC;

  // funct3 010/011 are holes in the branch space
  assign legal =
    (is_ld | is_st | is_op | is_opi |
     is_jal | is_jalr | is_lui | is_aui |
     (is_br & (f3[2:1] != 2'b01)));

  assign a_d = is_br | is_jal | is_aui;
  assign b_d = ~is_op;

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:         taken = br_eq;
      3'b001:         taken = ~br_eq;
      3'b100, 3'b110: taken = br_lt;
      3'b101, 3'b111: taken = ~br_lt;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_d = 3'd0;
    unique case (1'b1)
      is_st:           imm_d = 3'd1;
      is_br:           imm_d = 3'd2;
      is_lui, is_aui:  imm_d = 3'd3;
      is_jal:          imm_d = 3'd4;
      default:         imm_d = 3'd0;
    endcase
  end

  always_comb begin
    alu_d = 4'b0000;
    unique case (1'b1)
      is_op:   alu_d = {instr[30], f3};
      is_opi:  alu_d = {instr[30] & (f3 == 3'b101), f3};
      is_lui:  alu_d = 4'b1111;
      default: alu_d = 4'b0000;
    endcase
  end

  assign stall = ((st == FETCH) | (st == MEMORY))
               & ~mem.mem_ready;
  assign tout  = stall
               & (cnt >= TO_W'(TIMEOUT - 1));

  always_comb begin
    cnt_nxt = '0;
    if (stall && !tout)
      cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
      bus_q <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      if (set_ill) ill_q <= 1'b1;
      if (set_bus) bus_q <= 1'b1;
    end
  end

  always_comb begin
    st_nxt      = st;
    set_ill     = 1'b0;
    set_bus     = 1'b0;
    pc_sel      = 1'b0;
    pc_wen      = 1'b0;
    ir_wen      = 1'b0;
    imm_sel     = 3'd0;
    a_sel       = 1'b0;
    b_sel       = 1'b0;
    br_un       = 1'b0;
    alu_op      = 4'b0000;
    wb_sel      = 2'd0;
    reg_wen     = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;

    // datapath selects held stable from EXECUTE to writeback
    if (st inside {EXECUTE, MEMORY, WRITEBACK}) begin
      imm_sel = imm_d;
      a_sel   = a_d;
      b_sel   = b_d;
      alu_op  = alu_d;
    end

    unique case (st)
      FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_wen = 1'b1;
          st_nxt = DECODE;
        end else if (tout) begin
          if (TRAP_EN) begin
            st_nxt  = TRAP;
            set_bus = 1'b1;
          end else begin
            pc_wen = 1'b1;
          end
        end
      end
      DECODE: begin
        imm_sel = imm_d;
        if (!legal) begin
          if (TRAP_EN) begin
            st_nxt  = TRAP;
            set_ill = 1'b1;
          end else begin
            pc_wen = 1'b1;
            st_nxt = FETCH;
          end
        end else begin
          st_nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        if (is_br) begin
          pc_wen = 1'b1;
          pc_sel = taken;
          br_un  = f3[1];
          st_nxt = FETCH;
        end else if (is_ld || is_st) begin
          st_nxt = MEMORY;
        end else begin
          st_nxt = WRITEBACK;
        end
      end
      MEMORY: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = is_st;
        if (mem.mem_ready) begin
          if (is_st) begin
            pc_wen = 1'b1;
            st_nxt = FETCH;
          end else begin
            st_nxt = WRITEBACK;
          end
        end else if (tout) begin
          if (TRAP_EN) begin
            st_nxt  = TRAP;
            set_bus = 1'b1;
          end else begin
            pc_wen = 1'b1;
            st_nxt = FETCH;
          end
        end
      end
      WRITEBACK: begin
        reg_wen = 1'b1;
        pc_wen  = 1'b1;
        if (is_jal || is_jalr) begin
          wb_sel = 2'd2;
          pc_sel = 1'b1;
        end else begin
          wb_sel = is_ld ? 2'd0 : 2'd1;
        end
        st_nxt = FETCH;
      end
      TRAP: begin
      end
      default: st_nxt = FETCH;
    endcase

    if (rst) begin
      set_ill     = 1'b0;
      set_bus     = 1'b0;
      pc_sel      = 1'b0;
      pc_wen      = 1'b0;
      ir_wen      = 1'b0;
      imm_sel     = 3'd0;
      a_sel       = 1'b0;
      b_sel       = 1'b0;
      br_un       = 1'b0;
      alu_op      = 4'b0000;
      wb_sel      = 2'd0;
      reg_wen     = 1'b0;
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
    end
  end

  assign illegal = ill_q & ~rst;
  assign bus_err = bus_q & ~rst;
  assign state   = rst ? 3'd0 : st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: trap and
// no-trap builds driven by hand-coded instructions.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst0;
  logic [31:0] instr;
  logic        br_eq, br_lt;

  logic       pc_sel, pc_wen, ir_wen;
  logic [2:0] imm_sel;
  logic       a_sel, b_sel, br_un;
  logic [3:0] alu_op;
  logic [1:0] wb_sel;
  logic       reg_wen, illegal, bus_err;
  logic [2:0] state;

  logic       pc_sel0, pc_wen0, ir_wen0;
  logic [2:0] imm_sel0;
  logic       a_sel0, b_sel0, br_un0;
  logic [3:0] alu_op0;
  logic [1:0] wb_sel0;
  logic       reg_wen0, illegal0, bus_err0;
  logic [2:0] state0;

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;
  int bad;

  multicycle_ctrl_if mif ();
  multicycle_ctrl_if mif0 ();

  multicycle_ctrl #(
    .TIMEOUT(8), .TO_W(4), .TRAP_EN(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .instr(instr),
    .br_eq(br_eq), .br_lt(br_lt), .mem(mif),
    .pc_sel(pc_sel), .pc_wen(pc_wen),
    .ir_wen(ir_wen), .imm_sel(imm_sel),
    .a_sel(a_sel), .b_sel(b_sel), .br_un(br_un),
    .alu_op(alu_op), .wb_sel(wb_sel),
    .reg_wen(reg_wen), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  multicycle_ctrl #(
    .TIMEOUT(8), .TO_W(4), .TRAP_EN(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst0), .instr(instr),
    .br_eq(br_eq), .br_lt(br_lt), .mem(mif0),
    .pc_sel(pc_sel0), .pc_wen(pc_wen0),
    .ir_wen(ir_wen0), .imm_sel(imm_sel0),
    .a_sel(a_sel0), .b_sel(b_sel0), .br_un(br_un0),
    .alu_op(alu_op0), .wb_sel(wb_sel0),
    .reg_wen(reg_wen0), .illegal(illegal0),
    .bus_err(bus_err0), .state(state0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
    n++;
  endtask

  task to_exec(input logic [31:0] i);
    instr = i;
    tick;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    rst0 = 1'b1;
    mif.mem_ready  = 1'b1;
    mif0.mem_ready = 1'b0;
    instr = 32'h0;
    br_eq = 1'b0;
    br_lt = 1'b0;
    tick;
    tick;
    chk("rst_state", state, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_irw", ir_wen, 0);
    chk("rst_ill", illegal, 0);
    chk("rst0_req", mif0.mem_req, 0);

    rst = 1'b0;
    #1;
    chk("f_req", mif.mem_req, 1);
    chk("f_we", mif.mem_we, 0);
    chk("f_irw", ir_wen, 1);

    // ADD x3,x1,x2
    n = 0;
    to_exec(32'h002081B3);
    chk("add_st", state, 2);
    chk("add_alu", alu_op, 4'b0000);
    chk("add_bsel", b_sel, 0);
    chk("add_rw_ex", reg_wen, 0);
    tick;
    chk("add_wb_st", state, 4);
    chk("add_rw", reg_wen, 1);
    chk("add_wbs", wb_sel, 1);
    chk("add_pcw", pc_wen, 1);
    chk("add_pcs", pc_sel, 0);
    tick;
    chk("add_cyc", n, 4);
    chk("add_end", state, 0);

    // BNE taken, BGEU not taken, BEQ taken
    br_eq = 1'b0;
    br_lt = 1'b0;
    to_exec(32'h00209463);
    chk("bne_pcw", pc_wen, 1);
    chk("bne_pcs", pc_sel, 1);
    chk("bne_un", br_un, 0);
    chk("bne_rw", reg_wen, 0);
    chk("bne_imm", imm_sel, 2);
    chk("bne_ab", {a_sel, b_sel}, 2'b11);
    tick;
    chk("bne_end", state, 0);
    br_lt = 1'b1;
    to_exec(32'h0020F463);
    chk("bgeu_pcw", pc_wen, 1);
    chk("bgeu_pcs", pc_sel, 0);
    chk("bgeu_un", br_un, 1);
    chk("bgeu_rw", reg_wen, 0);
    tick;
    br_eq = 1'b1;
    to_exec(32'h00208463);
    chk("beq_pcs", pc_sel, 1);
    tick;

    // LW with three wait cycles in MEMORY
    n = 0;
    to_exec(32'h0000A183);
    chk("lw_ex", state, 2);
    mif.mem_ready = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      mif.mem_ready = (k == 3);
      #1;
      chk("lw_mem",
          {state, mif.mem_req, mif.mem_we},
          {3'd3, 1'b1, 1'b0});
      tick;
    end
    chk("lw_wb", state, 4);
    chk("lw_wbs", wb_sel, 0);
    chk("lw_rw", reg_wen, 1);
    tick;
    chk("lw_cyc", n, 8);

    // SW zero-wait
    to_exec(32'h0020A023);
    tick;
    chk("sw_mem", state, 3);
    chk("sw_we", mif.mem_we, 1);
    chk("sw_pcw", pc_wen, 1);
    chk("sw_rw", reg_wen, 0);
    tick;
    chk("sw_end", state, 0);

    // JALR x1,0(x5)
    to_exec(32'h000280E7);
    tick;
    chk("jalr_wb", state, 4);
    chk("jalr_wbs", wb_sel, 2);
    chk("jalr_pcs", pc_sel, 1);
    chk("jalr_rw", reg_wen, 1);
    tick;

    // ALU op encodings
    to_exec(32'h4020D193);
    chk("srai_alu", alu_op, 4'b1101);
    chk("srai_b", b_sel, 1);
    tick;
    tick;
    to_exec(32'h40000093);
    chk("addi_alu", alu_op, 4'b0000);
    tick;
    tick;
    to_exec(32'h402081B3);
    chk("sub_alu", alu_op, 4'b1000);
    tick;
    tick;
    to_exec(32'h000010B7);
    chk("lui_alu", alu_op, 4'b1111);
    chk("lui_imm", imm_sel, 3);
    tick;
    tick;
    to_exec(32'h008000EF);
    chk("jal_imm", imm_sel, 4);
    chk("jal_a", a_sel, 1);
    tick;
    chk("jal_wb", {wb_sel, pc_sel}, 3'b101);
    tick;

    // reset during WRITEBACK suppresses writes
    to_exec(32'h002081B3);
    tick;
    rst = 1'b1;
    #1;
    chk("rstwb_rw", reg_wen, 0);
    chk("rstwb_pcw", pc_wen, 0);
    chk("rstwb_st", state, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("rstwb_f", mif.mem_req, 1);

    // ready in the timeout cycle wins
    mif.mem_ready = 1'b0;
    repeat (7) tick;
    chk("tow_st", state, 0);
    mif.mem_ready = 1'b1;
    #1;
    chk("tow_irw", ir_wen, 1);
    tick;
    chk("tow_dec", state, 1);
    chk("tow_be", bus_err, 0);
    tick;
    tick;
    tick;
    chk("tow_end", state, 0);

    // illegal opcode trap
    instr = 32'h0000007F;
    tick;
    chk("ill_dec", state, 1);
    tick;
    chk("ill_st", state, 5);
    chk("ill_flag", illegal, 1);
    bad = 0;
    repeat (20) begin
      tick;
      if (state != 3'd5 || pc_wen || ir_wen ||
          reg_wen || mif.mem_req || mif.mem_we)
        bad++;
    end
    chk("ill_hold", bad, 0);
    chk("ill_sticky", illegal, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mif.mem_ready = 1'b0;
    #1;
    chk("ill_rst_st", state, 0);
    chk("ill_rst_f", illegal, 0);

    // fetch bus timeout
    repeat (7) tick;
    chk("to_pre_st", state, 0);
    chk("to_pre_be", bus_err, 0);
    tick;
    chk("to_st", state, 5);
    chk("to_be", bus_err, 1);
    chk("to_req", mif.mem_req, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mif.mem_ready = 1'b1;
    #1;
    chk("to_rst_be", bus_err, 0);

    // no-trap build: abandon and refetch
    rst0 = 1'b0;
    #1;
    repeat (6) tick;
    chk("nt_pre_pcw", pc_wen0, 0);
    tick;
    chk("nt_pcw", pc_wen0, 1);
    chk("nt_pcs", pc_sel0, 0);
    tick;
    chk("nt_after", {state0, pc_wen0}, 4'b0000);
    chk("nt_be", bus_err0, 0);
    repeat (7) tick;
    chk("nt_pcw2", pc_wen0, 1);

    // no-trap build: illegal becomes NOP
    mif0.mem_ready = 1'b1;
    #1;
    chk("nt_irw", ir_wen0, 1);
    tick;
    chk("nti_st", state0, 1);
    chk("nti_pcw", pc_wen0, 1);
    chk("nti_ill", illegal0, 0);
    tick;
    chk("nti_end", state0, 0);

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
